// File: rtl/i2c_master_rs.sv
// I2C master with runtime write/read counts, repeated START, NACK detection and SCL stretching.
// Each bit is four quarters: SDA moves in Q0, SCL released in Q2, SDA sampled at the end of Q3.
//   state   | meaning
//   IDLE    | bus released, rdy=1, waiting for vin
//   START   | SDA falls while SCL high, then SCL pulled low
//   ADDR    | shifting out {ain, rw}
//   ACK_CHK | 9th bit, SDA released, slave ACK sampled
//   WR      | shifting out one write byte
//   RSTART  | repeated START before the read address
//   RD      | shifting in one read byte
//   ACK_GEN | master ACK (or NACK on the last byte), byte stored
//   STOP    | SDA rises while SCL high, then back to IDLE
module i2c_master_rs #(
    parameter int PRESCALER = 40,
    parameter int MAX_W = 4,
    parameter int MAX_R = 4,
    localparam int WW = $clog2(MAX_W + 1),
    localparam int RW = $clog2(MAX_R + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl_i,
    output logic               scl_oe,
    input  logic               sda_i,
    output logic               sda_oe,
    input  logic [6:0]         ain,
    input  logic [WW-1:0]      n_wr,
    input  logic [RW-1:0]      n_rd,
    input  logic [8*MAX_W-1:0] din,
    input  logic               vin,
    output logic               rdy,
    output logic [8*MAX_R-1:0] dout,
    output logic               vout,
    output logic               nack,
    output logic               busy
);

    localparam int QTR = PRESCALER / 4;
    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(QTR - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_CHK, S_WR, S_RSTART, S_RD, S_ACK_GEN, S_STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         scl_sync, sda_sync;
    logic               scl_s, sda_s;
    logic [CW-1:0]      cnt;
    logic [1:0]         qtr;
    logic               freeze, tick, bit_end, sda_hold;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg, wr_byte, rd_byte;
    logic               rw, addr_ack, last_rd;
    logic [WW-1:0]      wr_idx, n_wr_l, n_wr_c;
    logic [RW-1:0]      rd_idx, n_rd_l, n_rd_c;
    logic [8*MAX_W-1:0] din_l;
    logic [6:0]         ain_l;
    logic               scl_d, sda_d;

    assign scl_s   = scl_sync[1];
    assign sda_s   = sda_sync[1];
    assign rdy     = (state == S_IDLE);
    assign busy    = ~rdy;
    assign n_wr_c  = (n_wr > WW'(MAX_W)) ? WW'(MAX_W) : n_wr;
    assign n_rd_c  = (n_rd > RW'(MAX_R)) ? RW'(MAX_R) : n_rd;
    // quarter timer stalls in Q2 until the released SCL is actually seen high
    assign freeze  = (qtr == 2'd2) && !scl_s;
    assign tick    = (state != S_IDLE) && (cnt == '0) && !freeze;
    assign bit_end = tick && (qtr == 2'd3);
    assign rd_byte = {shreg[6:0], sda_s};
    assign last_rd = (rd_idx == n_rd_l);
    // SDA follows SCL's fall by one cycle so a Q0 data change never looks like START/STOP
    assign sda_hold = (state != S_IDLE) && (qtr == 2'd0) && (cnt == CNT_LOAD);

    always_comb begin
        wr_byte = 8'h00;
        for (int k = 0; k < MAX_W; k++)
            if (wr_idx == WW'(k)) wr_byte = din_l[8*(MAX_W-1-k) +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_d     = (qtr < 2'd2);
        sda_d     = 1'b0;
        case (state)
            S_IDLE: begin
                scl_d = 1'b0;
                if (vin) state_nxt = S_START;
            end
            S_START: begin
                scl_d = (qtr == 2'd3);
                sda_d = qtr[1];
                if (bit_end) state_nxt = S_ADDR;
            end
            S_ADDR, S_WR: begin
                sda_d = ~shreg[7];
                if (bit_end && bit_cnt == 3'd0) state_nxt = S_ACK_CHK;
            end
            S_ACK_CHK: begin
                if (bit_end) begin
                    if (sda_s)                state_nxt = S_STOP;
                    else if (addr_ack)        state_nxt = rw ? S_RD : ((n_wr_l != '0) ? S_WR : S_STOP);
                    else if (wr_idx == n_wr_l) state_nxt = (n_rd_l != '0) ? S_RSTART : S_STOP;
                    else                      state_nxt = S_WR;
                end
            end
            S_RSTART: begin
                sda_d = (qtr == 2'd3);
                if (bit_end) state_nxt = S_ADDR;
            end
            S_RD: begin
                if (bit_end && bit_cnt == 3'd0) state_nxt = S_ACK_GEN;
            end
            S_ACK_GEN: begin
                sda_d = ~last_rd;
                if (bit_end) state_nxt = last_rd ? S_STOP : S_RD;
            end
            S_STOP: begin
                sda_d = (qtr != 2'd3);
                if (bit_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            cnt      <= CNT_LOAD;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd7;
            shreg    <= 8'h00;
            rw       <= 1'b0;
            addr_ack <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            n_wr_l   <= '0;
            n_rd_l   <= '0;
            din_l    <= '0;
            ain_l    <= 7'h00;
            dout     <= '0;
            vout     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            vout   <= 1'b0;
            scl_oe <= scl_d;
            if (!sda_hold) sda_oe <= sda_d;

            if (state == S_IDLE) begin
                cnt <= CNT_LOAD;
                qtr <= 2'd0;
            end else if (tick) begin
                cnt <= CNT_LOAD;
                qtr <= qtr + 2'd1;
            end else if (!freeze) begin
                cnt <= cnt - 1'b1;
            end

            if (state == S_IDLE && vin) begin
                ain_l   <= ain;
                n_wr_l  <= n_wr_c;
                n_rd_l  <= n_rd_c;
                din_l   <= din;
                nack    <= 1'b0;
                wr_idx  <= '0;
                rd_idx  <= '0;
                bit_cnt <= 3'd7;
                rw      <= (n_wr_c == '0) && (n_rd_c != '0);
                shreg   <= {ain, (n_wr_c == '0) && (n_rd_c != '0)};
            end

            if (bit_end) begin
                case (state)
                    S_ADDR, S_WR: begin
                        if (bit_cnt == 3'd0) begin
                            addr_ack <= (state == S_ADDR);
                            if (state == S_WR) wr_idx <= wr_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                    S_ACK_CHK: begin
                        bit_cnt <= 3'd7;
                        if (sda_s) nack <= 1'b1;
                        if (state_nxt == S_WR) shreg <= wr_byte;
                    end
                    S_RSTART: begin
                        rw      <= 1'b1;
                        shreg   <= {ain_l, 1'b1};
                        bit_cnt <= 3'd7;
                    end
                    S_RD: begin
                        shreg <= rd_byte;
                        if (bit_cnt == 3'd0) begin
                            for (int i = 0; i < MAX_R; i++)
                                if (rd_idx == RW'(i)) dout[8*(MAX_R-1-i) +: 8] <= rd_byte;
                            rd_idx <= rd_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    S_ACK_GEN: bit_cnt <= 3'd7;
                    S_STOP:    vout <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_rs.sv
// Bench for i2c_master_rs: behavioural I2C slave on the bus, transaction-level model feeding a
// scoreboard, and a monitor that checks every vout completion against it.
module tb_i2c_master_rs;
    localparam int PRESCALER = 40;
    localparam int QTR = PRESCALER / 4;

    typedef struct packed {
        logic        nack;
        logic [31:0] dout;
        logic [31:0] wb;
        logic [2:0]  nw;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_oe, sda_oe, rdy, vout, nack, busy;
    logic [6:0]  ain = 7'h00;
    logic [2:0]  n_wr = 3'd0, n_rd = 3'd0;
    logic [31:0] din = 32'h0, dout;
    logic        vin = 1'b0;
    logic        s_scl_hold = 1'b0, s_sda_low = 1'b0;
    logic        scl_line, sda_line;

    assign scl_line = ~scl_oe & ~s_scl_hold;
    assign sda_line = ~sda_oe & ~s_sda_low;

    i2c_master_rs #(.PRESCALER(PRESCALER), .MAX_W(4), .MAX_R(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_line), .scl_oe(scl_oe), .sda_i(sda_line),
        .sda_oe(sda_oe), .ain(ain), .n_wr(n_wr), .n_rd(n_rd), .din(din), .vin(vin),
        .rdy(rdy), .dout(dout), .vout(vout), .nack(nack), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    exp_t sb[$];
    logic [31:0] model_dout = 32'h0;

    // slave configuration and observations
    bit          s_present = 1'b1, s_stretch = 1'b0;
    logic [7:0]  s_rd [4];
    int          s_wnack = 99;
    int          hold_cnt = 0, s_rc = 0, s_ridx = 0;
    bit          s_attend = 0, s_tx = 0, s_is_addr = 0, s_rwbit = 0, s_mack = 0;
    logic [7:0]  s_sh = 8'h00;
    bit          pscl = 1, psda = 1, in_high = 0;
    int          got_starts = 0, got_nw = 0, hi_cnt = 0, min_high = 1000000;
    logic [31:0] got_w = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // I2C slave at address 0x48
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_sda_low = 0; s_scl_hold = 0; hold_cnt = 0;
                s_attend = 0; s_tx = 0; s_rc = 0; in_high = 0;
                got_starts = 0; got_nw = 0; got_w = 0; min_high = 1000000;
                pscl = 1; psda = 1;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) s_scl_hold = 0;
                end
                if (pscl && scl_line && psda && !sda_line) begin
                    got_starts++;
                    s_rc = 0; s_attend = 1; s_is_addr = 1; s_tx = 0; s_sda_low = 0;
                end else if (pscl && scl_line && !psda && sda_line) begin
                    s_attend = 0; s_tx = 0;
                end else if (!pscl && scl_line) begin
                    in_high = 1; hi_cnt = 1;
                    if (s_attend) begin
                        if (s_rc < 8 && !s_tx) s_sh = {s_sh[6:0], sda_line};
                        if (s_rc == 8 && s_tx) s_mack = !sda_line;
                        s_rc++;
                    end
                end else if (pscl && !scl_line) begin
                    if (in_high && hi_cnt < min_high) min_high = hi_cnt;
                    in_high = 0;
                    if (s_stretch) begin s_scl_hold = 1; hold_cnt = 100; end
                    if (s_attend && s_rc == 8) begin
                        if (s_tx) s_sda_low = 0;
                        else if (s_is_addr) begin
                            if (s_sh[7:1] == 7'h48 && s_present) begin
                                s_sda_low = 1; s_rwbit = s_sh[0];
                            end else s_attend = 0;
                        end else begin
                            got_w = {got_w[23:0], s_sh};
                            s_sda_low = (got_nw != s_wnack);
                            got_nw++;
                        end
                    end else if (s_attend && s_rc == 9) begin
                        s_rc = 0; s_sda_low = 0;
                        if (s_is_addr) begin
                            s_is_addr = 0;
                            if (s_rwbit) begin s_tx = 1; s_ridx = 0; end
                        end else if (s_tx) begin
                            if (s_mack && s_ridx < 3) s_ridx++;
                            else s_tx = 0;
                        end
                        if (s_tx) s_sda_low = !s_rd[s_ridx][7];
                    end else if (s_attend && s_tx && s_rc >= 1 && s_rc <= 7) begin
                        s_sda_low = !s_rd[s_ridx][7 - s_rc];
                    end
                end else if (scl_line && in_high) begin
                    hi_cnt++;
                end
                pscl = scl_line; psda = sda_line;
            end
        end
    end

    // completion monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && vout) begin
                if (sb.size() == 0) check("unexpected_vout", vout, 0);
                else begin
                    e = sb.pop_front();
                    check("nack", nack, e.nack);
                    check("dout", dout, e.dout);
                    check("write_bytes", got_w, e.wb);
                    check("write_count", got_nw, e.nw);
                    check("start_count", got_starts, e.st);
                    check("rdy_busy_at_vout", {busy, rdy}, 2'b01);
                    check("scl_high_min_ok", (min_high >= QTR), 1);
                    got_w = 0; got_nw = 0; got_starts = 0; min_high = 1000000;
                end
            end
        end
    end

    task automatic model(input logic [6:0] a, input logic [2:0] nw, input logic [2:0] nr,
                         input logic [31:0] d, output exp_t e);
        int nwc, nrc;
        nwc = (nw > 4) ? 4 : int'(nw);
        nrc = (nr > 4) ? 4 : int'(nr);
        e.nack = 0; e.dout = model_dout; e.wb = 0; e.nw = 0; e.st = 1;
        if (!(s_present && a == 7'h48)) e.nack = 1;
        else begin
            for (int k = 0; k < nwc; k++) begin
                e.wb = {e.wb[23:0], d[8*(3-k) +: 8]};
                e.nw = e.nw + 3'd1;
                if (k == s_wnack) begin e.nack = 1; break; end
            end
            if (!e.nack && nrc > 0) begin
                if (nwc > 0) e.st = 2;
                for (int i = 0; i < nrc; i++) e.dout[8*(3-i) +: 8] = s_rd[i];
            end
        end
        model_dout = e.dout;
    endtask

    task automatic do_txn(input logic [6:0] a, input logic [2:0] nw, input logic [2:0] nr,
                          input logic [31:0] d, input bit expect_done, input bit busy_poke);
        exp_t e;
        for (int i = 0; i < 2000 && !rdy; i++) @(negedge clk);
        check("rdy_before_vin", rdy, 1);
        if (expect_done) begin
            model(a, nw, nr, d, e);
            sb.push_back(e);
        end
        ain = a; n_wr = nw; n_rd = nr; din = d; vin = 1;
        @(negedge clk);
        vin = 0;
        check("busy_after_vin", busy, 1);
        if (busy_poke) begin
            repeat (300) @(negedge clk);
            ain = 7'h11; n_wr = 3'd0; n_rd = 3'd0; din = $urandom; vin = 1;
            repeat (3) @(negedge clk);
            vin = 0;
        end
        if (expect_done) begin
            for (int i = 0; i < 30000 && sb.size() != 0; i++) @(negedge clk);
            check("txn_complete", sb.size(), 0);
            if (sb.size() != 0) sb.delete();
        end
    endtask

    task automatic set_rd(input logic [31:0] v);
        for (int i = 0; i < 4; i++) s_rd[i] = v[8*(3-i) +: 8];
    endtask

    initial begin
        #(950000);
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        set_rd(32'h1234_5678);
        repeat (3) @(negedge clk);
        check("reset_scl_oe", scl_oe, 0);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_rdy_busy", {busy, rdy}, 2'b01);
        check("reset_vout_nack", {vout, nack}, 2'b00);
        check("reset_dout", dout, 32'h0);
        rst_n = 1;
        repeat (5) @(negedge clk);

        do_txn(7'h48, 3'd1, 3'd2, {8'h0A, 24'($urandom)}, 1, 0);
        do_txn(7'h48, 3'd3, 3'd0, 32'h0102_03FF, 1, 0);
        s_present = 0;
        do_txn(7'h48, 3'd2, 3'd2, $urandom, 1, 0);
        s_present = 1;
        set_rd(32'hA55A_C33C);
        s_stretch = 1;
        do_txn(7'h48, 3'd1, 3'd2, {8'h0A, 24'h0}, 1, 0);
        s_stretch = 0;
        do_txn(7'h48, 3'd2, 3'd1, $urandom, 1, 1);
        do_txn(7'h48, 3'd0, 3'd0, $urandom, 1, 0);
        do_txn(7'h48, 3'd0, 3'd3, $urandom, 1, 0);
        do_txn(7'h48, 3'd7, 3'd6, $urandom, 1, 0);
        s_wnack = 1;
        do_txn(7'h48, 3'd3, 3'd2, $urandom, 1, 0);
        s_wnack = 99;

        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            set_rd($urandom);
            s_present = ($urandom_range(5) != 0);
            s_wnack = ($urandom_range(4) == 0) ? int'($urandom_range(3)) : 99;
            a = ($urandom_range(7) == 0) ? 7'($urandom) : 7'h48;
            do_txn(a, 3'($urandom), 3'($urandom), $urandom, 1, 0);
        end
        s_present = 1; s_wnack = 99;

        set_rd(32'h1234_5678);
        do_txn(7'h48, 3'd1, 3'd2, 32'h0A00_0000, 0, 0);
        for (int i = 0; i < 5000 && !(s_tx && s_ridx == 0 && s_rc >= 3); i++) @(negedge clk);
        check("reached_read_byte", s_tx, 1);
        rst_n = 0;
        #1;
        check("abort_scl_oe", scl_oe, 0);
        check("abort_sda_oe", sda_oe, 0);
        model_dout = 32'h0;
        repeat (5) @(negedge clk);
        check("abort_rdy_dout", {rdy, dout}, {1'b1, 32'h0});
        rst_n = 1;
        repeat (5) @(negedge clk);
        set_rd(32'h9ABC_DEF0);
        do_txn(7'h48, 3'd2, 3'd4, $urandom, 1, 0);

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
